// File: rtl/decim_pkg.sv
// Shared sample definitions for the filter stage and the decimator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package decim_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample buffer with occupancy count and a drop indication.
// Latency: a push is visible at head/not_empty one cycle later.
// Backpressure: a push into a full buffer without a same-edge pop is dropped and flagged.
import decim_pkg::*;

module sample_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      push,
  input  logic signed [SAMPLE_W-1:0] push_data,
  input  logic                      pop_req,
  output logic signed [SAMPLE_W-1:0] head,
  output logic                      not_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sample_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           full;
  logic           do_pop;
  logic           do_push;

  // A pop frees a slot on the same edge, so a full buffer still accepts a push then.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop_req && (count_q != '0);
    do_push = push && (!full || do_pop);
    dropped = push && full && !do_pop;
  end

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/sample_decimator.sv
// Keeps one of every DECIM filtered samples (or their floor average when DECIM_AVG_EN is defined) and buffers it.
// Latency: decimated sample appears at data_out/valid_out one cycle after the emit strobe.
// Backpressure: consumer pops with ack_in; a full buffer drops new samples and sets sticky overflow_out.
import decim_pkg::*;

module sample_decimator #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          ready_in,
  input  logic signed [SAMPLE_W-1:0]    signal_in,
  output logic signed [SAMPLE_W-1:0]    data_out,
  output logic                          valid_out,
  input  logic                          ack_in,
  output logic [$clog2(FIFO_DEPTH):0]   count_out,
  output logic                          overflow_out,
  input  logic                          clear_ovf_in
);

  localparam int SH = $clog2(DECIM);
  localparam int PW = (DECIM > 1) ? SH : 1;

  logic [PW-1:0] phase;
  logic          emit;
  sample_t       push_val;
  logic          dropped;

  assign emit = ready_in && (phase == PW'(DECIM - 1));

  // Phase advances once per input sample and wraps at the end of each group.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      phase <= '0;
    end else if (ready_in) begin
      phase <= emit ? '0 : phase + PW'(1);
    end
  end

`ifdef DECIM_AVG_EN
  localparam int ACC_W = SAMPLE_W + SH;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_avg;

  // Group sum including the current sample; the shift is arithmetic so the mean floors.
  always_comb begin
    sample_ext = ACC_W'(signal_in);
    acc_sum    = acc + sample_ext;
    acc_avg    = acc_sum >>> SH;
    push_val   = acc_avg[SAMPLE_W-1:0];
  end

  // Accumulate each sample; restart the sum after the group is emitted.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      acc <= '0;
    end else if (ready_in) begin
      acc <= emit ? '0 : acc_sum;
    end
  end
`else
  assign push_val = signal_in;
`endif

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (emit),
    .push_data (push_val),
    .pop_req   (ack_in),
    .head      (data_out),
    .not_empty (valid_out),
    .count     (count_out),
    .dropped   (dropped)
  );

  // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      overflow_out <= 1'b0;
    end else if (dropped) begin
      overflow_out <= 1'b1;
    end else if (clear_ovf_in) begin
      overflow_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
module tb_sample_decimator;

  logic               clk_in;
  logic               rst_n_in;
  logic               ready_in;
  logic signed [15:0] signal_in;
  logic signed [15:0] data_out;
  logic               valid_out;
  logic               ack_in;
  logic [3:0]         count_out;
  logic               overflow_out;
  logic               clear_ovf_in;

  int checks = 0;
  int errors = 0;

  sample_decimator #(
    .DECIM      (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .ready_in     (ready_in),
    .signal_in    (signal_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ack_in       (ack_in),
    .count_out    (count_out),
    .overflow_out (overflow_out),
    .clear_ovf_in (clear_ovf_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Decimated value of pulse group g, where the group holds samples 4g-3 .. 4g.
  function automatic int grp_val(input int g);
`ifdef DECIM_AVG_EN
    return (16 * g - 6) >>> 2;
`else
    return 4 * g;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input int v);
    ready_in  = 1'b1;
    signal_in = 16'(v);
    tick();
    ready_in  = 1'b0;
  endtask

  int exp_first;
  int exp_single;

  initial begin
    rst_n_in     = 1'b0;
    ready_in     = 1'b0;
    signal_in    = '0;
    ack_in       = 1'b0;
    clear_ovf_in = 1'b0;
    // Reset with sideband inputs active: reset must override them.
    ack_in = 1'b1; clear_ovf_in = 1'b1; ready_in = 1'b1; signal_in = 16'sd77;
    tick(); tick();
    ack_in = 1'b0; clear_ovf_in = 1'b0; ready_in = 1'b0;
    check("reset_valid", valid_out, 0);
    check("reset_count", count_out, 0);
    check("reset_data", data_out, 0);
    check("reset_ovf", overflow_out, 0);
    rst_n_in = 1'b1;
    tick();

    // First group: output appears one cycle after the fourth strobe.
    pulse(100); pulse(200); pulse(300);
    check("no_emit_before_4th", valid_out, 0);
    pulse(400);
`ifdef DECIM_AVG_EN
    exp_first = 250;
`else
    exp_first = 400;
`endif
    check("first_valid", valid_out, 1);
    check("first_data", data_out, exp_first);
    check("first_count", count_out, 1);
    ack_in = 1'b1; tick(); ack_in = 1'b0;
    check("drain_count", count_out, 0);
    check("drain_valid", valid_out, 0);

    // Negative group: average floors toward minus infinity.
    pulse(-1); pulse(-2); pulse(-3); pulse(-4);
`ifdef DECIM_AVG_EN
    check("neg_data", data_out, -3);
`else
    check("neg_data", data_out, -4);
`endif
    ack_in = 1'b1; tick(); ack_in = 1'b0;
    check("neg_drain", count_out, 0);

    // Fill to capacity, then overflow.
    for (int i = 1; i <= 32; i++) pulse(i);
    check("fill_count", count_out, 8);
    check("fill_no_ovf", overflow_out, 0);
    for (int i = 33; i <= 36; i++) pulse(i);
    check("ovf_set", overflow_out, 1);
    check("ovf_count", count_out, 8);
    check("ovf_head", data_out, grp_val(1));

    // Clear alone, then an overflow coincident with a clear keeps the flag.
    clear_ovf_in = 1'b1; tick(); clear_ovf_in = 1'b0;
    check("clear_alone", overflow_out, 0);
    pulse(37); pulse(38); pulse(39);
    clear_ovf_in = 1'b1; pulse(40); clear_ovf_in = 1'b0;
    check("ovf_beats_clear", overflow_out, 1);
    clear_ovf_in = 1'b1; tick(); clear_ovf_in = 1'b0;
    check("clear_after", overflow_out, 0);

    // Full buffer with a pop on the emit edge: both happen, no overflow.
    pulse(41); pulse(42); pulse(43);
    ack_in = 1'b1; pulse(44); ack_in = 1'b0;
    check("full_pp_count", count_out, 8);
    check("full_pp_ovf", overflow_out, 0);
    for (int g = 2; g <= 8; g++) begin
      check($sformatf("fifo_order_g%0d", g), data_out, grp_val(g));
      ack_in = 1'b1; tick(); ack_in = 1'b0;
    end
    check("tail_value", data_out, grp_val(11));
    ack_in = 1'b1; tick(); ack_in = 1'b0;
    check("empty_after_drain", valid_out, 0);

    // Acknowledge while empty is ignored.
    ack_in = 1'b1; tick(); ack_in = 1'b0;
    check("ack_empty_count", count_out, 0);
    check("ack_empty_valid", valid_out, 0);

    // Reset mid-group discards the partial group.
    pulse(5); pulse(6);
    rst_n_in = 1'b0; ready_in = 1'b1; signal_in = 16'sd9; tick();
    rst_n_in = 1'b1; ready_in = 1'b0;
    pulse(10); pulse(20); pulse(30);
    check("partial_discard", count_out, 0);
    pulse(40);
`ifdef DECIM_AVG_EN
    exp_single = 25;
`else
    exp_single = 40;
`endif
    check("after_rst_count", count_out, 1);
    check("after_rst_data", data_out, exp_single);

    // Pop and push on the same edge with one entry: head replaced, count held.
    pulse(1); pulse(2); pulse(3);
    ack_in = 1'b1; pulse(6); ack_in = 1'b0;
    check("pp_one_count", count_out, 1);
`ifdef DECIM_AVG_EN
    check("pp_one_data", data_out, 3);
`else
    check("pp_one_data", data_out, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_decimator.md
SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 Parameter DECIM, default 4: decimation ratio; SHALL be one of 1, 2, 4, 8, 16.
REQ-002 Parameter FIFO_DEPTH, default 8: output buffer entries; SHALL be a power of two, >= 2.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset; synchronous, active-low.
REQ-005 ready_in  input  1  single-cycle strobe: signal_in holds a new filtered sample.
REQ-006 signal_in  input  16  signed filtered sample.
REQ-007 data_out  output  16  signed head-of-buffer sample.
REQ-008 valid_out  output  1  high while the buffer is non-empty.
REQ-009 ack_in  input  1  consumer pops head when valid_out && ack_in.
REQ-010 count_out  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-011 overflow_out  output  1  sticky: a decimated sample was dropped.
REQ-012 clear_ovf_in  input  1  clears overflow_out.

Function
REQ-013 A phase counter 0..DECIM-1 SHALL advance by one on each cycle ready_in is high, wrapping DECIM-1 -> 0.
REQ-014 A cycle with ready_in high and phase == DECIM-1 SHALL be an emit cycle; a decimated sample is pushed on that clock edge.
REQ-015 Without averaging (see Configuration), the pushed value SHALL be signal_in of the emit cycle.
REQ-016 valid_out SHALL rise, with data_out equal to the pushed value, on the cycle after an emit into an empty buffer (latency 1 cycle).
REQ-017 A pop SHALL occur on each edge where valid_out && ack_in; ack_in while valid_out is low SHALL be ignored.
REQ-018 Push into a full buffer with no simultaneous pop SHALL drop the new sample, leave contents and count_out unchanged, and set overflow_out.
REQ-019 Push and pop on the same edge SHALL both take effect, including when full (count_out unchanged, no overflow) and empty-push (no pop possible).
REQ-020 Buffer order SHALL be first-in first-out; read and write pointers wrap modulo FIFO_DEPTH.
REQ-021 overflow_out SHALL clear on an edge with clear_ovf_in high, except that a same-cycle overflow event SHALL win (remains 1).
REQ-022 data_out SHALL always present the head slot; its value while valid_out is low is not checked beyond reset.
REQ-023 DECIM == 1 SHALL emit on every ready_in.

Reset
REQ-024 With rst_n_in low at a rising edge: phase 0, accumulator 0, pointers 0, count_out 0, valid_out 0, data_out 0, overflow_out 0, all buffer slots 0.
REQ-025 Reset SHALL override any same-cycle ready_in, ack_in, or clear_ovf_in; partial decimation groups SHALL be discarded.

Configuration
REQ-026 Macro DECIM_AVG_EN: when defined, the block SHALL keep a signed accumulator of width 16+log2(DECIM), add signal_in on every ready_in, and on an emit push (accumulator + signal_in) arithmetically shifted right by log2(DECIM) (floor), then zero the accumulator.
REQ-027 When DECIM_AVG_EN is undefined, no accumulator SHALL exist and REQ-015 applies.

Structure
REQ-028 Package decim_pkg SHALL hold SAMPLE_W = 16 and typedef sample_t (signed 16-bit), shared with the filter stage.
REQ-029 Buffer SHALL be a sub-module sample_fifo (synchronous, parameterized depth, count output); decimation/phase logic lives in sample_decimator.

Verification (DECIM=4, FIFO_DEPTH=8)
REQ-030 Reset, pulses 100,200,300,400, ack_in low -> one cycle after 4th pulse valid_out=1, data_out=400 (250 with DECIM_AVG_EN), count_out=1.
REQ-031 DECIM_AVG_EN, pulses -1,-2,-3,-4 -> data_out=-3 (floor of -2.5).
REQ-032 36 pulses, ack_in low -> count_out=8 after 32nd, overflow_out=1 after 36th, data_out still first decimated value.
REQ-033 Full buffer, ack_in high on emit cycle -> count_out stays 8, overflow_out stays 0, new value at tail.
REQ-034 2 pulses, rst_n_in low one cycle, then 4 pulses 10,20,30,40 -> single output 40 (25 with DECIM_AVG_EN).
REQ-035 Overflow event coincident with clear_ovf_in -> overflow_out=1; clear_ovf_in next cycle alone -> 0.
